// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, state codes and datapath select encodings for multicycle_control.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ERROR     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_IMM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: sorts a raw opcode into the instruction class that picks the post-decode path.
// Optional feature: MULTICYCLE_CONTROL_BNE_EN makes opcode 0x05 a branch instead of illegal.
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_class_e  op_class
);

  // Pure lookup; anything not recognised is reported as illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_LW, OP_SW:     op_class = CLS_MEM;
      OP_RTYPE:         op_class = CLS_RTYPE;
      OP_ADDI, OP_ORI:  op_class = CLS_IMM;
      OP_BEQ:           op_class = CLS_BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
      OP_BNE:           op_class = CLS_BRANCH;
`endif
      OP_J:             op_class = CLS_JUMP;
      default:          op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle main control FSM with a memory-wait timeout watchdog.
// Optional feature: define MULTICYCLE_CONTROL_BNE_EN to add bne (opcode 0x05) and the BranchNe_o port.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       MemtoReg_o,
  output logic       IRWrite_o,
  output logic       ALUSrcA_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic [1:0] PCSource_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] ALUSrcB_o,
  output logic       done_o,
  output logic       illegal_o,
  output logic       err_o,
`ifdef MULTICYCLE_CONTROL_BNE_EN
  output logic       BranchNe_o,
`endif
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             waiting;
  logic             timeout_hit;
  op_class_e        op_class;

  op_class_decode u_op_class (
    .op       (Op_i),
    .op_class (op_class)
  );

  // The timeout fires on the stalled cycle that would bring the wait count up to MEM_TIMEOUT.
  assign cnt_inc     = cnt_q + 1'b1;
  assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout_hit = TIMEOUT_EN && !mem_ready_i && (cnt_inc == TIMEOUT_CNT);
  assign state_o     = state_q;

  // State, latched opcode and wait counter; reset abandons whatever access is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) op_q <= Op_i;
    end
  end

  // Any state change restarts the count, so every memory access starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting && !mem_ready_i) cnt_d = cnt_inc;
  end

  // Next state plus every datapath strobe; everything is zero unless a state asserts it.
  always_comb begin
    state_d       = state_q;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    IRWrite_o     = 1'b0;
    ALUSrcA_o     = 1'b0;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    PCSource_o    = PCSRC_ALU;
    ALUOp_o       = ALUOP_ADD;
    ALUSrcB_o     = SRCB_B;
    done_o        = 1'b0;
    illegal_o     = 1'b0;
    err_o         = 1'b0;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    BranchNe_o    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM_SH;
        case (op_class)
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_RTYPE:  state_d = S_EXECUTE;
          CLS_IMM:    state_d = S_IMM_EXEC;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        done_o     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          done_o  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_EXECUTE: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_RTYPE;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        done_o     = 1'b1;
        state_d    = S_FETCH;
      end
      S_IMM_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = (op_q == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite_o = 1'b1;
        done_o     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALUOP_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
        done_o        = 1'b1;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        BranchNe_o    = (op_q == OP_BNE);
`endif
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = PCSRC_JUMP;
        done_o     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ERROR: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenarios plus random traffic, checked every cycle against an
// instruction-plan model for two instances (MEM_TIMEOUT 16 and 4).
// Honours MULTICYCLE_CONTROL_BNE_EN the same way the design does.
module tb_multicycle_control;
  import ctrl_pkg::*;

`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       done;
    logic       illegal;
    logic       err;
    logic       bne;
    logic [3:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [5:0] op = 6'h00;
  obs_t       got [2];

  int checks = 0;
  int errors = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, alu_src_a, reg_write, reg_dst, done, illegal, err, bne;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT((g == 0) ? 16 : 4), .CNT_W(5)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .Op_i          (op),
      .mem_ready_i   (ready),
      .PCWrite_o     (pc_write),
      .PCWriteCond_o (pc_write_cond),
      .IorD_o        (ior_d),
      .MemRead_o     (mem_read),
      .MemWrite_o    (mem_write),
      .MemtoReg_o    (mem_to_reg),
      .IRWrite_o     (ir_write),
      .ALUSrcA_o     (alu_src_a),
      .RegWrite_o    (reg_write),
      .RegDst_o      (reg_dst),
      .PCSource_o    (pc_source),
      .ALUOp_o       (alu_op),
      .ALUSrcB_o     (alu_src_b),
      .done_o        (done),
      .illegal_o     (illegal),
      .err_o         (err),
`ifdef MULTICYCLE_CONTROL_BNE_EN
      .BranchNe_o    (bne),
`endif
      .state_o       (state)
    );
`ifndef MULTICYCLE_CONTROL_BNE_EN
    assign bne = 1'b0;
`endif
    assign got[g] = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg, ir_write,
                     alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b,
                     done, illegal, err, bne, state};
  end

  // Model: each instance is a phase plus the list of phases the decoded instruction still has to run.
  state_e     m_st    [2];
  logic [5:0] m_op    [2];
  int         m_waits [2];
  state_e     m_plan  [2][3];
  int         m_len   [2];
  int         m_pos   [2];
  bit         m_valid [2] = '{1'b0, 1'b0};
  int         m_tmo   [2] = '{16, 4};

  function automatic void planFor(input logic [5:0] o, output state_e p0, output state_e p1,
                                  output state_e p2, output int len);
    p0 = S_FETCH; p1 = S_FETCH; p2 = S_FETCH; len = 0;
    case (o)
      6'h23: begin p0 = S_MEM_ADDR; p1 = S_MEM_READ; p2 = S_MEM_WB; len = 3; end
      6'h2B: begin p0 = S_MEM_ADDR; p1 = S_MEM_WRITE; len = 2; end
      6'h00: begin p0 = S_EXECUTE; p1 = S_ALU_WB; len = 2; end
      6'h08, 6'h0D: begin p0 = S_IMM_EXEC; p1 = S_IMM_WB; len = 2; end
      6'h04: begin p0 = S_BRANCH; len = 1; end
      6'h05: if (BNE_EN) begin p0 = S_BRANCH; len = 1; end
      6'h02: begin p0 = S_JUMP; len = 1; end
      default: len = 0;
    endcase
  endfunction

  function automatic obs_t expectObs(input state_e s, input logic rdy, input logic [5:0] live,
                                     input logic [5:0] lat);
    obs_t   e;
    state_e p0, p1, p2;
    int     len;
    e = '0;
    e.state = s;
    case (s)
      S_FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:    begin e.alu_src_b = 2'b11; planFor(live, p0, p1, p2, len); e.illegal = (len == 0); end
      S_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_MEM_READ:  begin e.mem_read = 1; e.ior_d = 1; end
      S_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; e.done = 1; end
      S_MEM_WRITE: begin e.mem_write = 1; e.ior_d = 1; e.done = rdy; end
      S_EXECUTE:   begin e.alu_src_a = 1; e.alu_op = 2'b11; end
      S_ALU_WB:    begin e.reg_write = 1; e.reg_dst = 1; e.done = 1; end
      S_IMM_EXEC:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = (lat == 6'h0D) ? 2'b10 : 2'b00; end
      S_IMM_WB:    begin e.reg_write = 1; e.done = 1; end
      S_BRANCH:    begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; e.done = 1;
        e.bne = BNE_EN && (lat == 6'h05);
      end
      S_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; e.done = 1; end
      S_ERROR:     e.err = 1;
      default:     ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
    end
  endtask

  // Compare both instances against the model for this cycle, then advance the model.
  task automatic modelCheck();
    bit is_mem;
    for (int m = 0; m < 2; m++) begin
      if (m_valid[m])
        checkOutput((m == 0) ? "model_t16" : "model_t4", 32'(got[m]),
                    32'(expectObs(m_st[m], ready, op, m_op[m])));
      is_mem = (m_st[m] == S_FETCH) || (m_st[m] == S_MEM_READ) || (m_st[m] == S_MEM_WRITE);
      if (rst) begin
        m_st[m] = S_IDLE; m_op[m] = 6'h00; m_waits[m] = 0; m_valid[m] = 1'b1;
      end else if (m_valid[m]) begin
        if (m_st[m] == S_IDLE) begin
          if (start) begin m_st[m] = S_FETCH; m_waits[m] = 0; end
        end else if (m_st[m] == S_ERROR) begin
          m_st[m] = S_ERROR;
        end else if (m_st[m] == S_DECODE) begin
          m_op[m] = op;
          planFor(op, m_plan[m][0], m_plan[m][1], m_plan[m][2], m_len[m]);
          m_waits[m] = 0;
          if (m_len[m] == 0) m_st[m] = S_FETCH;
          else begin m_st[m] = m_plan[m][0]; m_pos[m] = 1; end
        end else if (is_mem && !ready) begin
          m_waits[m]++;
          if (m_tmo[m] != 0 && m_waits[m] == m_tmo[m]) m_st[m] = S_ERROR;
        end else begin
          m_waits[m] = 0;
          if (m_st[m] == S_FETCH) m_st[m] = S_DECODE;
          else if (m_pos[m] < m_len[m]) begin m_st[m] = m_plan[m][m_pos[m]]; m_pos[m]++; end
          else m_st[m] = S_FETCH;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [5:0] o);
    @(posedge clk);
    #1;
    rst = r; start = s; ready = rd; op = o;
    @(negedge clk);
    modelCheck();
  endtask

  // Reset, then leave IDLE so the next cycle is the first FETCH.
  task automatic restart();
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00);
  endtask

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    logic [3:0]  seq [5];
    logic [19:0] exp_seq;
    logic [1:0]  wb_bits;
    int          done_at, done_cnt, mw_cnt, ill_cnt, err_at, err_cnt;
    logic        strobes, ill2;
    logic [3:0]  st3, st5;
    logic [5:0]  br_bits;
    logic [5:0]  op_tab [10] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};

    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h23);
    checkOutput("reset_idle_t16", 32'(got[0]), 32'h0);
    checkOutput("reset_idle_t4", 32'(got[1]), 32'h0);

    // lw, zero-wait memory
    restart();
    done_at = 0; wb_bits = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 6'h23);
      if (k <= 5) seq[k-1] = got[0].state;
      if (got[0].done && done_at == 0) begin
        done_at = k; wb_bits = {got[0].reg_write, got[0].mem_to_reg};
      end
    end
    exp_seq = {S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB};
    checkOutput("lw_latency", 32'(done_at), 32'd5);
    checkOutput("lw_state_seq", 32'({seq[0], seq[1], seq[2], seq[3], seq[4]}), 32'(exp_seq));
    checkOutput("lw_wb_strobes", 32'(wb_bits), 32'd3);

    // sw with three stalled cycles in MEM_WRITE
    restart();
    done_at = 0; done_cnt = 0; mw_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, !(k >= 4 && k <= 6), 6'h2B);
      mw_cnt += int'(got[0].mem_write);
      if (got[0].done) begin done_cnt++; if (done_at == 0) done_at = k; end
    end
    checkOutput("sw_latency", 32'(done_at), 32'd7);
    checkOutput("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    checkOutput("sw_done_count", 32'(done_cnt), 32'd1);

    // illegal opcode 0x3F
    restart();
    ill_cnt = 0; strobes = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h3F);
    ill_cnt += int'(got[0].illegal);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h3F);
    ill_cnt += int'(got[0].illegal);
    ill2 = got[0].illegal;
    strobes |= got[0].reg_write | got[0].mem_write | got[0].pc_write;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h3F);
    ill_cnt += int'(got[0].illegal);
    strobes |= got[0].reg_write | got[0].mem_write | got[0].pc_write;
    checkOutput("illegal_in_decode", 32'(ill2), 32'd1);
    checkOutput("illegal_pulse_count", 32'(ill_cnt), 32'd1);
    checkOutput("illegal_back_to_fetch", 32'(got[0].state), 32'(S_FETCH));
    checkOutput("illegal_no_strobes", 32'(strobes), 32'd0);

    // beq: branch controls in cycle 3
    restart();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h04);
    br_bits = {got[0].pc_write_cond, got[0].pc_source, got[0].alu_op, got[0].done};
    checkOutput("beq_cycle3_controls", 32'(br_bits), 32'b1_01_01_1);
    checkOutput("beq_no_bne", 32'(got[0].bne), 32'd0);

    // opcode 0x05
    restart();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h05);
    ill2 = got[0].illegal;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h05);
    st3 = got[0].state;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    checkOutput("bne_not_illegal", 32'(ill2), 32'd0);
    checkOutput("bne_branch_ne", 32'({st3, got[0].bne}), 32'({S_BRANCH, 1'b1}));
`else
    checkOutput("bne_disabled_illegal", 32'(ill2), 32'd1);
    checkOutput("bne_disabled_fetch", 32'(st3), 32'(S_FETCH));
`endif

    // reset in the middle of MEM_READ
    restart();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h23);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h23);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h23);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h23);
    checkOutput("stalled_in_mem_read", 32'(got[0].state), 32'(S_MEM_READ));
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h23);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h00);
    checkOutput("reset_mid_read_idle", 32'(got[0]), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkOutput("resume_at_fetch", 32'(got[0].state), 32'(S_FETCH));

    // timeout: instance 1 has MEM_TIMEOUT=4, memory never ready in FETCH
    restart();
    err_at = 0; err_cnt = 0; st5 = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, (k == 7), (k >= 8), 6'h00);
      if (got[1].err && err_at == 0) err_at = k;
      err_cnt += int'(got[1].err);
      if (k == 5) st5 = got[0].state;
    end
    checkOutput("timeout_error_cycle", 32'(err_at), 32'd5);
    checkOutput("timeout_err_sticky", 32'(err_cnt), 32'd6);
    checkOutput("timeout16_still_fetch", 32'(st5), 32'(S_FETCH));
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
    checkOutput("timeout_reset_idle", 32'(got[1]), 32'h0);

    // random traffic, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 9)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
